reservation_station: RTL
========================

// Module: reservation_station
// PURPOSE
//  Issue queue directly downstream of rename. Buffers renamed micro-ops (opcode, ps1, ps2, pd, instr),
//  tracks physical-register readiness via an internal scoreboard, captures wakeup broadcasts from
//  execution units, and issues the oldest fully-ready entry to execute, one per cycle.
// PARAMETERS
//  DEPTH     8   entries; compacting queue, index 0 = oldest
//  PREG_W    6   physical register tag width
//  NUM_PREG  64  physical registers tracked by scoreboard (2**PREG_W)
// PORTS
//  clk           in   1       clock; one clock, all state on posedge
//  rst_n         in   1       reset is asynchronous and active-low
//  flush         in   1       sync: drop all entries, scoreboard all-ready
//  disp_valid    in   1       rename presents a micro-op
//  disp_ready    out  1       queue accepts; = (count < DEPTH)
//  disp_opcode   in   7       opcode from rename
//  disp_ps1      in   PREG_W  source 1 tag
//  disp_ps2      in   PREG_W  source 2 tag (meaningful only if src2 used)
//  disp_pd       in   PREG_W  destination tag
//  disp_instr    in   32      raw instruction (immediates)
//  wake0_valid   in   1       ALU result broadcast
//  wake0_tag     in   PREG_W
//  wake1_valid   in   1       LSU result broadcast
//  wake1_tag     in   PREG_W
//  iss_valid     out  1       an entry is issuing
//  iss_ready     in   1       execute accepts
//  iss_opcode    out  7
//  iss_ps1       out  PREG_W
//  iss_ps2       out  PREG_W
//  iss_pd        out  PREG_W
//  iss_instr     out  32
//  count         out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (rst_n=0, async): all entries invalid, count=0, scoreboard all 1 (ready), all iss_* = 0,
//    disp_ready=1. flush has identical effect at posedge; flush overrides same-cycle dispatch/issue.
//  - src2 used iff opcode is 0110011 (R-type) or 0100011 (SW); otherwise src2 ready forced 1.
//  - Dispatch (disp_valid & disp_ready): entry appended at index count. rdy1/rdy2 = scoreboard bit OR
//    same-cycle wakeup tag match. Scoreboard[disp_pd] cleared to 0 at same edge.
//  - Wakeup: each valid wake port sets scoreboard[tag]=1 and sets rdy1/rdy2 of every valid entry with
//    matching tag. Both ports may hit the same tag; result is simply ready.
//  - Conflict: wakeup tag == disp_pd same cycle -> clear wins (new producer outstanding).
//  - Select: combinational; lowest-index valid entry with rdy1&rdy2 drives iss_* and iss_valid=1.
//    iss_* = 0 when iss_valid=0. Readiness uses registered bits: wake-to-issue latency 1 cycle.
//  - Issue (iss_valid & iss_ready): selected entry removed; entries above shift down one index,
//    preserving age order. Dispatch same cycle lands at index count-1. count updates by +1/-1/0.
//  - Full: disp_ready=0 when count==DEPTH, even if an issue fires that cycle (no same-cycle refill).
//  - Empty: iss_valid=0. Dispatch into empty queue issues no earlier than next cycle.
//  - Stalled issue (iss_ready=0): iss_* held stable while selection unchanged; an older entry becoming
//    ready may replace the selection (no handshake lock).
// CONFIGURATION
//  RS_WAKE_BYPASS_EN defined: select also treats same-cycle wakeup tag matches as ready, giving
//    0-cycle wake-to-issue; disp path unchanged (new entries still not issuable in dispatch cycle).
//  Undefined (default): 1-cycle wake-to-issue as above.
// TESTING
//  1 Reset then dispatch ADD ps1=3,ps2=4,pd=10 with sb all-ready -> iss_valid next cycle, iss_pd=10, count 1->0.
//  2 Dispatch A pd=10, then B ps1=10 -> B not issued; wake0 tag=10 -> B issues 1 cycle later
//    (0 cycles with RS_WAKE_BYPASS_EN).
//  3 Fill 8 entries all blocked on tag 20 -> disp_ready=0, count=8; wake1 tag=20 -> issue order 0..7, oldest first.
//  4 Same cycle: dispatch pd=12 and wake0 tag=12 -> scoreboard[12]=0; later consumer of 12 stays blocked.
//  5 ADDI ps2=any not-ready tag -> issues (src2 ignored); SW with ps2 not ready -> held.
//  6 Assert flush with 5 entries, then rst_n pulse mid-issue -> count=0, iss_valid=0, all tags ready.

Source files
------------

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - compacting issue queue with physical-register scoreboard and wakeup capture
// Optional feature macro RS_WAKE_BYPASS_EN: select also sees same-cycle wakeups (0-cycle wake-to-issue).
module reservation_station #(
    parameter int DEPTH    = 8,
    parameter int PREG_W   = 6,
    parameter int NUM_PREG = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [6:0]               disp_opcode,
    input  logic [PREG_W-1:0]        disp_ps1,
    input  logic [PREG_W-1:0]        disp_ps2,
    input  logic [PREG_W-1:0]        disp_pd,
    input  logic [31:0]              disp_instr,
    input  logic                     wake0_valid,
    input  logic [PREG_W-1:0]        wake0_tag,
    input  logic                     wake1_valid,
    input  logic [PREG_W-1:0]        wake1_tag,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [6:0]               iss_opcode,
    output logic [PREG_W-1:0]        iss_ps1,
    output logic [PREG_W-1:0]        iss_ps2,
    output logic [PREG_W-1:0]        iss_pd,
    output logic [31:0]              iss_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH-1:0]    ent_rdy1;
    logic [DEPTH-1:0]    ent_rdy2;
    logic [6:0]          ent_op    [DEPTH];
    logic [PREG_W-1:0]   ent_ps1   [DEPTH];
    logic [PREG_W-1:0]   ent_ps2   [DEPTH];
    logic [PREG_W-1:0]   ent_pd    [DEPTH];
    logic [31:0]         ent_instr [DEPTH];
    logic [NUM_PREG-1:0] scoreboard;

    logic [DEPTH-1:0]    nxt_valid;
    logic [DEPTH-1:0]    nxt_rdy1;
    logic [DEPTH-1:0]    nxt_rdy2;
    logic [6:0]          nxt_op    [DEPTH];
    logic [PREG_W-1:0]   nxt_ps1   [DEPTH];
    logic [PREG_W-1:0]   nxt_ps2   [DEPTH];
    logic [PREG_W-1:0]   nxt_pd    [DEPTH];
    logic [31:0]         nxt_instr [DEPTH];
    logic [NUM_PREG-1:0] nxt_sb;
    logic [CNT_W-1:0]    nxt_count;

    logic [NUM_PREG-1:0] wake_vec;
    logic [DEPTH-1:0]    eff_rdy1;
    logic [DEPTH-1:0]    eff_rdy2;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic                do_disp;
    logic                do_issue;
    logic [CNT_W-1:0]    app_idx;
    logic                new_rdy1;
    logic                new_rdy2;

    // One-hot-or of both broadcast ports; a tag hit on either port reads as ready.
    always_comb begin
        wake_vec = '0;
        if (wake0_valid) wake_vec[wake0_tag] = 1'b1;
        if (wake1_valid) wake_vec[wake1_tag] = 1'b1;
    end

    always_comb begin
        eff_rdy1 = '0;
        eff_rdy2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKE_BYPASS_EN
            eff_rdy1[i] = ent_rdy1[i] | wake_vec[ent_ps1[i]];
            eff_rdy2[i] = ent_rdy2[i] | wake_vec[ent_ps2[i]];
`else
            eff_rdy1[i] = ent_rdy1[i];
            eff_rdy2[i] = ent_rdy2[i];
`endif
        end
    end

    // Scan from the top so the lowest (oldest) ready index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && eff_rdy1[i] && eff_rdy2[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Flush masks the issue so execute never consumes an op that is being discarded.
    always_comb begin
        iss_valid  = sel_found && !flush;
        iss_opcode = '0;
        iss_ps1    = '0;
        iss_ps2    = '0;
        iss_pd     = '0;
        iss_instr  = '0;
        if (iss_valid) begin
            iss_opcode = ent_op[sel_idx];
            iss_ps1    = ent_ps1[sel_idx];
            iss_ps2    = ent_ps2[sel_idx];
            iss_pd     = ent_pd[sel_idx];
            iss_instr  = ent_instr[sel_idx];
        end
    end

    assign disp_ready = (count < CNT_W'(DEPTH));
    assign do_disp    = disp_valid && disp_ready && !flush;
    assign do_issue   = iss_valid && iss_ready;
    assign app_idx    = do_issue ? (count - 1'b1) : count;
    assign nxt_count  = count + CNT_W'(do_disp) - CNT_W'(do_issue);

    always_comb begin
        new_rdy1 = scoreboard[disp_ps1] | wake_vec[disp_ps1];
        new_rdy2 = scoreboard[disp_ps2] | wake_vec[disp_ps2];
        if (!(disp_opcode == OP_RTYPE || disp_opcode == OP_STORE)) new_rdy2 = 1'b1;
    end

    // Set by wakeups, then cleared by the new producer: the clear wins on a same-tag conflict.
    always_comb begin
        nxt_sb = scoreboard | wake_vec;
        if (do_disp) nxt_sb[disp_pd] = 1'b0;
    end

    always_comb begin
        logic [IDX_W-1:0] cur;
        logic [IDX_W-1:0] src;
        logic             src_ok;
        cur       = '0;
        src       = '0;
        src_ok    = 1'b0;
        nxt_valid = '0;
        nxt_rdy1  = '0;
        nxt_rdy2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nxt_op[i]    = '0;
            nxt_ps1[i]   = '0;
            nxt_ps2[i]   = '0;
            nxt_pd[i]    = '0;
            nxt_instr[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            cur    = IDX_W'(i);
            src    = cur;
            src_ok = 1'b1;
            // Entries at or above the issued slot slide down one place.
            if (do_issue && cur >= sel_idx) begin
                src    = cur + 1'b1;
                src_ok = (cur != IDX_W'(DEPTH - 1));
            end
            if (src_ok && ent_valid[src]) begin
                nxt_valid[i] = 1'b1;
                nxt_rdy1[i]  = ent_rdy1[src] | wake_vec[ent_ps1[src]];
                nxt_rdy2[i]  = ent_rdy2[src] | wake_vec[ent_ps2[src]];
                nxt_op[i]    = ent_op[src];
                nxt_ps1[i]   = ent_ps1[src];
                nxt_ps2[i]   = ent_ps2[src];
                nxt_pd[i]    = ent_pd[src];
                nxt_instr[i] = ent_instr[src];
            end
            if (do_disp && CNT_W'(cur) == app_idx) begin
                nxt_valid[i] = 1'b1;
                nxt_rdy1[i]  = new_rdy1;
                nxt_rdy2[i]  = new_rdy2;
                nxt_op[i]    = disp_opcode;
                nxt_ps1[i]   = disp_ps1;
                nxt_ps2[i]   = disp_ps2;
                nxt_pd[i]    = disp_pd;
                nxt_instr[i] = disp_instr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid  <= '0;
            ent_rdy1   <= '0;
            ent_rdy2   <= '0;
            count      <= '0;
            scoreboard <= '1;
            for (int i = 0; i < DEPTH; i++) begin
                ent_op[i]    <= '0;
                ent_ps1[i]   <= '0;
                ent_ps2[i]   <= '0;
                ent_pd[i]    <= '0;
                ent_instr[i] <= '0;
            end
        end else if (flush) begin
            ent_valid  <= '0;
            ent_rdy1   <= '0;
            ent_rdy2   <= '0;
            count      <= '0;
            scoreboard <= '1;
        end else begin
            ent_valid  <= nxt_valid;
            ent_rdy1   <= nxt_rdy1;
            ent_rdy2   <= nxt_rdy2;
            count      <= nxt_count;
            scoreboard <= nxt_sb;
            for (int i = 0; i < DEPTH; i++) begin
                ent_op[i]    <= nxt_op[i];
                ent_ps1[i]   <= nxt_ps1[i];
                ent_ps2[i]   <= nxt_ps2[i];
                ent_pd[i]    <= nxt_pd[i];
                ent_instr[i] <= nxt_instr[i];
            end
        end
    end

endmodule
